// File: rtl/syscall_console.sv
// Board-side syscall console: debounced GO strobe, halt-time display
// capture and an 8-digit active-low seven-segment scanner.
//
// Ports:
//   clk          system clock, rising edge
//   CLR          synchronous active-high reset
//   btn_go       raw GO push-button (async, bouncy, active-high)
//   cpu_halt     CPU halted on a syscall
//   cpu_display  CPU display word
//   go_pulse     one-cycle GO strobe to the CPU
//   halted_led   registered cpu_halt
//   an           digit enables, active-low (an[i] = digit i)
//   seg          segments, active-low, {dp,g,f,e,d,c,b,a}
module syscall_console #(
  parameter int DB_CYCLES = 1000000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        btn_go,
  input  logic        cpu_halt,
  input  logic [31:0] cpu_display,
  output logic        go_pulse,
  output logic        halted_led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int PW = $clog2(SCAN_DIV) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   shown;
  logic          prev_halt;

  logic [3:0]    nib;
  logic [7:0]    seg_nxt;
  logic [7:0]    an_nxt;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] r;
    case (v)
      4'h0:    r = 8'hC0;
      4'h1:    r = 8'hF9;
      4'h2:    r = 8'hA4;
      4'h3:    r = 8'hB0;
      4'h4:    r = 8'h99;
      4'h5:    r = 8'h92;
      4'h6:    r = 8'h82;
      4'h7:    r = 8'hF8;
      4'h8:    r = 8'h80;
      4'h9:    r = 8'h90;
      4'hA:    r = 8'h88;
      4'hB:    r = 8'h83;
      4'hC:    r = 8'hC6;
      4'hD:    r = 8'hA1;
      4'hE:    r = 8'h86;
      default: r = 8'h8E;
    endcase
    return r;
  endfunction

  always_comb begin
    nib     = shown[{idx, 2'b00} +: 4];
    seg_nxt = hex7(nib);
    an_nxt  = ~(8'b1 << idx);
    // Digit 0 carries the decimal point as a "halted" marker.
    if (idx == 3'd0 && cpu_halt)
      seg_nxt[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      deb        <= 1'b0;
      deb_q      <= 1'b0;
      db_cnt     <= '0;
      presc      <= '0;
      idx        <= 3'd0;
      shown      <= 32'd0;
      prev_halt  <= 1'b0;
      go_pulse   <= 1'b0;
      halted_led <= 1'b0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
    end else begin
      sync1 <= btn_go;
      sync2 <= sync1;

      // Any cycle agreeing with the accepted level restarts the count.
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      // Rise seen one cycle late; a rise while running is dropped.
      deb_q    <= deb;
      go_pulse <= deb & ~deb_q & cpu_halt;

      prev_halt  <= cpu_halt;
      halted_led <= cpu_halt;
      if (cpu_halt && !prev_halt)
        shown <= cpu_display;

      if (presc == SCAN_LAST) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_syscall_console.sv
// Scoreboard bench for syscall_console (DB_CYCLES=4, SCAN_DIV=2).
// Stimulus queues expected display samples and GO pulse cycles.
module tb_syscall_console;

  logic        clk = 1'b0;
  logic        CLR = 1'b1;
  logic        btn_go = 1'b0;
  logic        cpu_halt = 1'b0;
  logic [31:0] cpu_display = 32'd0;
  logic        go_pulse;
  logic        halted_led;
  logic [7:0]  an;
  logic [7:0]  seg;

  syscall_console #(.DB_CYCLES(4), .SCAN_DIV(2)) dut (
    .clk(clk), .CLR(CLR), .btn_go(btn_go),
    .cpu_halt(cpu_halt), .cpu_display(cpu_display),
    .go_pulse(go_pulse), .halted_led(halted_led),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    logic       led;
  } samp_t;

  samp_t sq[$];
  int    pq[$];
  int    cyc = 0;
  int    r_cyc = 0;
  int    passed = 0;
  int    total = 0;
  samp_t ms;
  int    mp;

  // Digits 0..7 of 32'h1234ABCD while halted (digit 0 has dp lit).
  logic [7:0] tab1 [8] = '{8'h21, 8'hC6, 8'h83, 8'h88,
                           8'h99, 8'hB0, 8'hA4, 8'hF9};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      ms = sq.pop_front();
      total++;
      if (ms.cyc != cyc || an !== ms.an || seg !== ms.seg ||
          halted_led !== ms.led)
        $display("FAIL disp@%0d: an=%h seg=%h led=%b need an=%h seg=%h led=%b (now %0d)",
                 ms.cyc, an, seg, halted_led, ms.an, ms.seg, ms.led, cyc);
      else
        passed++;
    end
    if (go_pulse === 1'b1) begin
      total++;
      if (pq.size() == 0) begin
        $display("FAIL go_pulse: unexpected pulse at cycle %0d", cyc);
      end else begin
        mp = pq.pop_front();
        if (mp != cyc)
          $display("FAIL go_pulse: pulse at cycle %0d, need %0d", cyc, mp);
        else
          passed++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [7:0] a,
                      input logic [7:0] s, input logic l);
    samp_t t;
    t.cyc = c; t.an = a; t.seg = s; t.led = l;
    sq.push_back(t);
  endtask

  // Caller holds cpu_halt=0 across the reset and the following edge.
  task automatic do_reset();
    int n;
    n = cyc;
    CLR = 1'b1;
    push(n + 1, 8'hFF, 8'hFF, 1'b0);
    push(n + 2, 8'hFE, 8'hC0, 1'b0);
    step();
    CLR = 1'b0;
    r_cyc = n + 1;
  endtask

  // mode 0: 1234ABCD table, mode 1: all F. cpu_halt=1 throughout.
  task automatic push_scan(input int first, input int count, input int mode);
    int         ix;
    logic [7:0] a;
    logic [7:0] s;
    logic [7:0] one;
    for (int e = first; e < first + count; e++) begin
      ix  = ((e - r_cyc - 1) / 2) % 8;
      one = 8'h01;
      a   = ~(one << ix);
      if (mode == 0) s = tab1[ix];
      else           s = (ix == 0) ? 8'h0E : 8'h8E;
      push(e, a, s, 1'b1);
    end
  endtask

  // Press at this negedge; a qualified pulse appears 7 edges later.
  task automatic press(input bit expect_pulse);
    btn_go = 1'b1;
    if (expect_pulse) pq.push_back(cyc + 7);
  endtask

  initial begin
    int a;
    int c;
    int m;
    step(3);

    // Reset values, then first scan output.
    do_reset();

    // Capture and full scan.
    step();
    cpu_display = 32'h1234ABCD;
    cpu_halt = 1'b1;
    push(cyc + 1, 8'hFE, 8'h40, 1'b1);
    push_scan(cyc + 2, 18, 0);
    step(20);

    // Display held while halted and the word changes.
    cpu_display = 32'hFFFFFFFF;
    push_scan(cyc + 2, 16, 0);
    step(18);

    // Drop and re-raise halt: new word captured.
    a = cyc;
    cpu_halt = 1'b0;
    step();
    cpu_halt = 1'b1;
    push_scan(a + 3, 17, 1);
    step(19);

    // Bouncy button, then steady high: one pulse.
    for (int i = 0; i < 20; i++) begin
      btn_go = (i % 2 == 0);
      step();
    end
    press(1'b1);
    step(15);
    btn_go = 1'b0;
    step(10);

    // Press while running is discarded.
    cpu_halt = 1'b0;
    step();
    press(1'b0);
    step(12);
    btn_go = 1'b0;
    step(10);
    cpu_halt = 1'b1;
    step();
    press(1'b1);
    step(12);
    btn_go = 1'b0;
    step(10);

    // Mid-operation reset on digit 5 with debounce counting.
    c = cyc + 6;
    while (((c - r_cyc - 1) % 16) != 10) c++;
    push(c, 8'hDF, 8'h8E, 1'b1);
    while (cyc < c - 4) step();
    btn_go = 1'b1;
    while (cyc < c) step();
    cpu_halt = 1'b0;
    do_reset();
    step();
    cpu_halt = 1'b1;
    m = c + 8;
    pq.push_back(m);
    step(14);
    btn_go = 1'b0;
    step(10);

    while (sq.size() > 0) begin
      ms = sq.pop_front();
      total++;
      $display("FAIL disp@%0d: never sampled", ms.cyc);
    end
    while (pq.size() > 0) begin
      mp = pq.pop_front();
      total++;
      $display("FAIL go_pulse: missing pulse due at %0d", mp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
